// File: rtl/load_store_unit.sv
// Load/store unit: takes one core memory request at a time and checks its
// funct3 code and alignment. Legal requests drive a single memory access,
// which is aborted if memory does not answer within TIMEOUT cycles. Each
// request ends with a one-cycle done pulse. For loads, the raw read word and
// the extender selects are kept for a downstream load extender.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] rd_word,
  output logic [1:0]  lsb_bits,
  output logic [2:0]  load_sel,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_MISAL = 2'b01;
  localparam logic [1:0] FC_ILL   = 2'b10;
  localparam logic [1:0] FC_TMO   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_fcode;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rd_word;
  logic [1:0]    r_lsb;
  logic [2:0]    r_load_sel;

  logic          w_accept;
  logic          w_illegal;
  logic          w_misal;
  logic          w_legal;
  logic [1:0]    w_fcode_acc;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [2:0]    w_load_sel;
  logic          w_timeout;
  logic          w_acc_done;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Stores only have b/h/w. Loads additionally allow bu/hu.
  assign w_illegal = is_store ? (funct3[2] || (funct3[1:0] == 2'b11))
                              : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));

  // Halfwords need addr[0]=0 and words need addr[1:0]=0. The unsigned
  // forms share the low funct3 bits, so one check covers both.
  assign w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  assign w_legal     = !w_illegal && !w_misal;
  assign w_fcode_acc = w_illegal ? FC_ILL : (w_misal ? FC_MISAL : FC_NONE);

  // Byte enables and lane-replicated write data for the accepted op.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00:   begin w_be = 4'b0001 << addr[1:0]; w_wdata = {4{wdata[7:0]}};  end
        2'b01:   begin w_be = 4'b0011 << addr[1:0]; w_wdata = {2{wdata[15:0]}}; end
        default: begin w_be = 4'b1111;              w_wdata = wdata;            end
      endcase
    end
  end

  // Map a load funct3 to the extender select. Illegal codes give lw (000).
  always_comb begin
    w_load_sel = 3'b000;
    case (funct3)
      3'b000:  w_load_sel = 3'b001;
      3'b001:  w_load_sel = 3'b010;
      3'b010:  w_load_sel = 3'b000;
      3'b100:  w_load_sel = 3'b011;
      3'b101:  w_load_sel = 3'b100;
      default: w_load_sel = 3'b000;
    endcase
  end

  // On the last allowed cycle, mem_ready still wins over the timeout.
  assign w_timeout  = (r_state == S_ACCESS) && !mem_ready && (r_cnt == CNT_MAX);
  assign w_acc_done = (r_state == S_ACCESS) && (mem_ready || w_timeout);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_legal ? S_ACCESS : S_RESP;
      S_ACCESS: if (w_acc_done) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Latch the memory command at a legal accept. It stays stable for all of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_accept && w_legal) begin
      r_we    <= is_store;
      r_be    <= w_be;
      r_addr  <= {addr[31:2], 2'b00};
      r_wdata <= w_wdata;
    end
  end

  // Count ACCESS cycles from 1. Clear the count once the access ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (w_accept && w_legal)     r_cnt <= CW'(1);
    else if (w_acc_done)              r_cnt <= '0;
    else if (r_state == S_ACCESS)     r_cnt <= r_cnt + 1'b1;
  end

  // Fault code: set from the decode at accept, or on a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_fcode <= FC_NONE;
    else if (w_accept)  r_fcode <= w_fcode_acc;
    else if (w_timeout) r_fcode <= FC_TMO;
  end

  // Capture the read word only when a load completes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_word <= 32'h0;
    else if ((r_state == S_ACCESS) && mem_ready && !r_we) r_rd_word <= mem_rdata;
  end

  // Extender selects follow each load accept. Store accepts leave them as they are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsb      <= 2'b00;
      r_load_sel <= 3'b000;
    end else if (w_accept && !is_store) begin
      r_lsb      <= addr[1:0];
      r_load_sel <= w_load_sel;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign mem_req    = (r_state == S_ACCESS);
  assign mem_we     = r_we;
  assign mem_be     = r_be;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign done       = (r_state == S_RESP);
  assign fault      = done && (r_fcode != FC_NONE);
  assign fault_code = done ? r_fcode : FC_NONE;
  assign rd_word    = r_rd_word;
  assign lsb_bits   = r_lsb;
  assign load_sel   = r_load_sel;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases, randomized transactions and a
// reset during an access. Expected values come from a transaction-level
// model of the op rules.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        done;
  logic [31:0] rd_word;
  logic [1:0]  lsb_bits;
  logic [2:0]  load_sel;
  logic        fault;
  logic [1:0]  fault_code;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .done(done), .rd_word(rd_word), .lsb_bits(lsb_bits), .load_sel(load_sel),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state as seen by the core.
  logic [31:0] m_rd;
  logic [1:0]  m_lsb;
  logic [2:0]  m_sel;
  bit          m_sel_ok;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(input logic [2:0] f3);
    case (f3)
      3'd0: return 3'd1;   // lb
      3'd1: return 3'd2;   // lh
      3'd2: return 3'd0;   // lw
      3'd4: return 3'd3;   // lbu
      default: return 3'd4; // hu
    endcase
  endfunction

  // One full transaction. lat is the ACCESS cycle on which memory answers.
  // A lat of 0 or above TO means memory never answers in time.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rdat);
    bit          ill, mis, got_rdy;
    int          nb;
    logic [1:0]  efc;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    nb  = 1 << f3[1:0];
    mis = !ill && ((a % nb) != 0);
    efc = ill ? 2'b10 : (mis ? 2'b01 : 2'b00);
    ebe = st ? 4'(((1 << nb) - 1) << a[1:0]) : 4'hF;
    ewd = (nb == 1) ? wd[7:0] * 32'h01010101 :
          (nb == 2) ? wd[15:0] * 32'h00010001 : wd;

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    // Keep req_valid high with junk fields. The unit is busy now, so it must ignore them.
    is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (!st) begin
      m_lsb = a[1:0];
      m_sel_ok = !ill;
      if (!ill) m_sel = sel_of(f3);
    end

    if (efc != 2'b00) begin
      chk("flt_mem_req", mem_req, 0);
      chk("flt_done", done, 1);
      chk("flt_fault", fault, 1);
      chk("flt_code", fault_code, efc);
    end else begin
      got_rdy = 0;
      for (int cyc = 1; cyc <= TO; cyc++) begin
        chk("acc_mem_req", mem_req, 1);
        chk("acc_req_ready", req_ready, 0);
        chk("acc_done", done, 0);
        chk("acc_mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("acc_mem_we", mem_we, st);
        chk("acc_mem_be", mem_be, ebe);
        if (st) chk("acc_mem_wdata", mem_wdata, ewd);
        if (cyc == lat) begin
          mem_ready = 1; mem_rdata = rdat; got_rdy = 1;
        end else begin
          mem_ready = 0; mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        mem_ready = 0;
        if (got_rdy) break;
      end
      efc = got_rdy ? 2'b00 : 2'b11;
      if (got_rdy && !st) m_rd = rdat;
      chk("rsp_mem_req", mem_req, 0);
      chk("rsp_done", done, 1);
      chk("rsp_fault", fault, efc != 2'b00);
      chk("rsp_code", fault_code, efc);
    end
    req_valid = 0;
    chk("rd_word", rd_word, m_rd);
    chk("lsb_bits", lsb_bits, m_lsb);
    if (m_sel_ok) chk("load_sel", load_sel, m_sel);
    @(posedge clk); #1;
    chk("post_done", done, 0);
    chk("post_fault", fault, 0);
    chk("post_code", fault_code, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_code"}, fault_code, 0);
    chk({tag, "_rd_word"}, rd_word, 0);
    chk({tag, "_lsb"}, lsb_bits, 0);
    chk({tag, "_sel"}, load_sel, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  initial begin
    m_rd = 0; m_lsb = 0; m_sel = 0; m_sel_ok = 1;
    #12;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(1, 3'b000, 32'h102, 32'hAB, 1, 32'h0);           // sb lane 2
    do_op(0, 3'b001, 32'h206, 32'h0, 1, 32'h8001_1234);    // lh
    do_op(0, 3'b010, 32'h301, 32'h0, 1, 32'hDEAD_BEEF);    // lw misaligned
    do_op(0, 3'b011, 32'h3, 32'h0, 1, 32'h1111_1111);      // illegal beats misaligned
    do_op(0, 3'b010, 32'h500, 32'h0, 0, 32'h2222_2222);    // timeout
    do_op(0, 3'b010, 32'h504, 32'h0, TO, 32'hCAFE_F00D);   // answer on last cycle
    do_op(1, 3'b001, 32'h10A, 32'h1234_5678, 3, 32'h0);    // sh upper half
    do_op(1, 3'b100, 32'h10, 32'h0, 1, 32'h0);             // illegal store code

    // Randomized transactions.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      do_op(1'($urandom), 3'($urandom), ra, $urandom, $urandom_range(1, TO + 3), $urandom);
    end

    // Reset while an access is in flight.
    req_valid = 1; is_store = 0; funct3 = 3'b010; addr = 32'h400; wdata = 0;
    @(posedge clk); #1;
    req_valid = 0; mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midacc_mem_req", mem_req, 1);
    rst_n = 0;
    #1;
    check_reset_vals("arst");
    @(posedge clk); #1;
    chk("arst_hold_done", done, 0);
    rst_n = 1;
    m_rd = 0; m_lsb = 0; m_sel = 0; m_sel_ok = 1;
    @(posedge clk); #1;
    do_op(0, 3'b100, 32'h601, 32'h0, 2, 32'h0BAD_F00D);    // lbu after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the bench always ends.
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles waiting for mem_ready before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core requests a memory op.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-justified.
REQ-010 SHALL have port mem_req  output  1  memory access strobe.
REQ-011 SHALL have port mem_we  output  1  memory write enable.
REQ-012 SHALL have port mem_be  output  4  byte enables; bit n enables byte lane n (little endian).
REQ-013 SHALL have port mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-015 SHALL have port mem_ready  input  1  memory completes the access this cycle.
REQ-016 SHALL have port mem_rdata  input  32  read word, valid when mem_ready.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port rd_word  output  32  captured raw read word for the load extender.
REQ-019 SHALL have port lsb_bits  output  2  captured addr[1:0] for the load extender.
REQ-020 SHALL have port load_sel  output  3  extender code: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu.
REQ-021 SHALL have port fault  output  1  asserted with done when op did not complete.
REQ-022 SHALL have port fault_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-024 SHALL accept a request when req_valid && req_ready, latching is_store, funct3, addr, wdata.
REQ-025 SHALL treat as illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-026 SHALL treat as misaligned: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0.
REQ-027 SHALL on an illegal or misaligned accept go IDLE->RESP without asserting mem_req; illegal takes priority over misaligned.
REQ-028 SHALL on a legal accept go IDLE->ACCESS; mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata held constant for every ACCESS cycle.
REQ-029 SHALL drive mem_be for stores: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111; loads 4'b1111.
REQ-030 SHALL drive mem_wdata: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-031 SHALL on mem_ready in ACCESS go to RESP; for loads capture mem_rdata into rd_word on that edge.
REQ-032 SHALL count ACCESS cycles from 1; on the TIMEOUT-th cycle without mem_ready go to RESP with fault_code 11; mem_ready on that same cycle wins (no fault).
REQ-033 SHALL in RESP assert done=1 for exactly one cycle, then return to IDLE; fault/fault_code valid only while done=1, else 0.
REQ-034 SHALL hold rd_word unchanged on stores, faults and timeouts.
REQ-035 SHALL update lsb_bits and load_sel at accept and hold them until the next accept; store accepts do not change them.
REQ-036 SHALL map load funct3 to load_sel: 000->001, 001->010, 010->000, 100->011, 101->100.
REQ-037 SHALL ignore req_valid outside IDLE; minimum legal accept-to-done latency 2 cycles (accept, 1 ACCESS cycle with mem_ready, done in RESP).

Reset
REQ-038 SHALL on rst_n=0 asynchronously enter IDLE; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0, fault=0, fault_code=00, rd_word=0, lsb_bits=00, load_sel=000, timeout counter=0.
REQ-039 SHALL abort any in-flight access on reset mid-ACCESS with no done pulse; req_ready=1 on the first clock edge after rst_n deasserts.

Verification
REQ-040 sb addr=0x102 wdata=0xAB -> mem_be=0100, mem_wdata=0xABABABAB, mem_addr=0x100, mem_we=1, done after mem_ready, fault=0.
REQ-041 lh addr=0x206, mem_rdata=0x8001_1234 with mem_ready on first ACCESS cycle -> done 2 cycles after accept, rd_word=0x80011234, lsb_bits=10, load_sel=010.
REQ-042 lw addr=0x301 -> no mem_req, done next cycle, fault=1, fault_code=01, rd_word unchanged.
REQ-043 load funct3=011 at addr=0x3 -> fault_code=10 (illegal beats misaligned), no mem_req.
REQ-044 legal load, mem_ready held 0 -> mem_req high for 16 cycles, then done with fault_code=11; variant with mem_ready on cycle 16 -> no fault.
REQ-045 rst_n low during ACCESS -> mem_req drops immediately, no done, outputs at reset values, new request accepted after release.
